// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter
// Brief    : Round-robin sharing of 6 board LEDs between 4 requesters, with a
//            tick-based minimum hold and optional per-source blink.
// Revision : 1.0
// ============================================================================
module led_arbiter #(
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [23:0] pattern,
    input  logic [3:0]  blink,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [5:0]  led,
    output logic        tick
);
    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST  = c_PW'(TICK_DIV - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OPEN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [c_PW-1:0] cnt_q, cnt_d;
    logic [c_HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]      rr_last_q, rr_last_d;
    logic [3:0]      grant_q, grant_d;
    logic [5:0]      led_q, led_d;
    logic            tick_q, tick_d;
    logic            phase_q, phase_d;
    logic            busy_q, busy_d;

    logic [1:0]      start_idx;
    logic [3:0]      req_rot;
    logic [1:0]      rot_pos;
    logic [1:0]      win_idx;
    logic            issue;

    // rr_last doubles as the owner index whenever grant is non-zero
    always_comb begin
        start_idx = rr_last_q + 2'd1;
        req_rot   = 4'({req, req} >> start_idx);
        if (req_rot[0])      rot_pos = 2'd0;
        else if (req_rot[1]) rot_pos = 2'd1;
        else if (req_rot[2]) rot_pos = 2'd2;
        else                 rot_pos = 2'd3;
        win_idx = start_idx + rot_pos;
    end

    always_comb begin
        cnt_d   = (cnt_q == c_PRE_LAST) ? '0 : cnt_q + c_PW'(1);
        tick_d  = (cnt_q == c_PRE_LAST);
        phase_d = phase_q ^ tick_q;

        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        issue      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) issue = 1'b1;
            end
            S_HOLD: begin
                if (tick_q) begin
                    if (hold_cnt_q == c_HOLD_LAST) state_d = S_OPEN;
                    else                           hold_cnt_d = hold_cnt_q + c_HW'(1);
                end
            end
            S_OPEN: begin
                if (|(req & ~grant_q)) begin
                    issue = 1'b1;
                end else if (~|(req & grant_q)) begin
                    grant_d = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = 4'd0;
                state_d = S_IDLE;
            end
        endcase

        // The search starts just past the current owner, so a hand-over from
        // OPEN always lands on a different source when one is requesting.
        if (issue) begin
            grant_d    = 4'b0001 << win_idx;
            rr_last_d  = win_idx;
            hold_cnt_d = '0;
            state_d    = (HOLD_TICKS == 0) ? S_OPEN : S_HOLD;
        end

        busy_d = (state_d != S_IDLE);

        if (grant_q == 4'd0)
            led_d = 6'd0;
        else
            led_d = pattern[{3'd0, rr_last_q} * 5'd6 +: 6] & {6{~blink[rr_last_q] | phase_q}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            rr_last_q  <= 2'd3;
            grant_q    <= 4'd0;
            led_q      <= 6'd0;
            tick_q     <= 1'b0;
            phase_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            led_q      <= led_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign led   = led_q;
    assign tick  = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_arbiter
// Brief    : Self-checking bench for led_arbiter (HOLD_TICKS=2 and 0 instances)
//            against a cycle-level behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_led_arbiter;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [23:0] pattern = 24'd0;
    logic [3:0]  blink = 4'd0;

    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b, tick_a, tick_b;
    logic [5:0] led_a, led_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per DUT instance
    int       m_owner[2];
    int       m_mode[2];   // 0 idle, 1 holding, 2 open
    int       m_held[2];
    int       m_last[2];
    int       m_edges[2];
    bit       m_phase[2];
    bit       m_tick[2];
    logic [5:0] m_led[2];

    always #5 clk = ~clk;

    led_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(2)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern), .blink(blink),
        .grant(grant_a), .busy(busy_a), .led(led_a), .tick(tick_a)
    );

    led_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(0)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern), .blink(blink),
        .grant(grant_b), .busy(busy_b), .led(led_b), .tick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int hold_of(input int m);
        return (m == 0) ? 2 : 0;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int m);
        m_owner[m] = -1;
        m_mode[m]  = 0;
        m_held[m]  = 0;
        m_last[m]  = 3;
        m_edges[m] = 0;
        m_phase[m] = 1'b1;
        m_tick[m]  = 1'b0;
        m_led[m]   = 6'd0;
    endtask

    task automatic model_edge(input int m);
        logic [5:0] led_n;
        int         w;
        bit         tick_now;
        if (rst) begin
            model_reset(m);
            return;
        end
        tick_now = m_tick[m];
        if (m_owner[m] < 0) begin
            led_n = 6'd0;
        end else begin
            led_n = pattern[6*m_owner[m] +: 6];
            if (blink[m_owner[m]] && !m_phase[m]) led_n = 6'd0;
        end
        w = -1;
        case (m_mode[m])
            0: if (req != 4'd0) w = rr_pick(req, m_last[m]);
            1: if (tick_now) begin
                   m_held[m]++;
                   if (m_held[m] == hold_of(m)) m_mode[m] = 2;
               end
            default: begin
                w = rr_pick(req & ~(4'b0001 << m_owner[m]), m_last[m]);
                if (w < 0 && !req[m_owner[m]]) begin
                    m_owner[m] = -1;
                    m_mode[m]  = 0;
                end
            end
        endcase
        if (w >= 0) begin
            m_owner[m] = w;
            m_last[m]  = w;
            m_held[m]  = 0;
            m_mode[m]  = (hold_of(m) == 0) ? 2 : 1;
        end
        m_led[m] = led_n;
        m_edges[m]++;
        m_tick[m] = (m_edges[m] % TD == 0);
        if (tick_now) m_phase[m] = !m_phase[m];
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        for (int m = 0; m < 2; m++) begin
            eg = (m_owner[m] < 0) ? 4'd0 : (4'b0001 << m_owner[m]);
            if (m == 0) begin
                check("a_grant", grant_a, eg);
                check("a_busy",  busy_a,  m_mode[m] != 0);
                check("a_led",   led_a,   m_led[m]);
                check("a_tick",  tick_a,  m_tick[m]);
            end else begin
                check("b_grant", grant_b, eg);
                check("b_busy",  busy_b,  m_mode[m] != 0);
                check("b_led",   led_b,   m_led[m]);
                check("b_tick",  tick_b,  m_tick[m]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;
        bit saw_zero;

        // Test 1: reset without any clock edge, then idle ticking
        #2;
        model_reset(0);
        model_reset(1);
        compare_all();
        check("rst_noclk_grant", grant_a, 4'd0);
        cycle();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick_a) cnt++;
            check("idle_led", led_a, 6'd0);
        end
        check("idle_tick_count", cnt, 5);

        // Test 2: single requester, grant then LEDs one cycle later
        req = 4'b0001; pattern = 24'h00002A; blink = 4'd0;
        cycle();
        check("t2_grant", grant_a, 4'b0001);
        check("t2_busy", busy_a, 1'b1);
        cycle();
        check("t2_led", led_a, 6'h2A);
        cnt = 0;
        guard = 0;
        while (cnt < 3 && guard < 40) begin
            cycle();
            if (tick_a) cnt++;
            guard++;
        end
        check("t2_ticks_seen", cnt, 3);
        req = 4'd0;
        cycle();
        check("t2_drop_grant", grant_a, 4'd0);
        check("t2_drop_led_lag", led_a, 6'h2A);
        cycle();
        check("t2_drop_led", led_a, 6'd0);

        // Test 3: simultaneous requests, hand-over with no zero gap
        do_reset();
        req = 4'b0101; pattern = 24'h0C0_02A;
        cycle();
        check("t3_first", grant_a, 4'b0001);
        saw_zero = 1'b0;
        guard = 0;
        while (grant_a == 4'b0001 && guard < 40) begin
            cycle();
            guard++;
        end
        check("t3_handover", grant_a, 4'b0100);
        guard = 0;
        while (grant_a == 4'b0100 && guard < 40) begin
            cycle();
            if (grant_a == 4'd0) saw_zero = 1'b1;
            guard++;
        end
        check("t3_back", grant_a, 4'b0001);
        check("t3_no_gap", saw_zero, 1'b0);

        // Test 4: blinking owner toggles with phase
        do_reset();
        req = 4'b0010; pattern = 24'h000FC0; blink = 4'b0010;
        for (int i = 0; i < 4; i++) cycle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (led_a == 6'h3F) cnt++;
        end
        check("t4_blink_on_cycles", cnt, 8);

        // Test 5: owner drops right after grant
        do_reset();
        blink = 4'd0; pattern = 24'h000015;
        req = 4'b0001;
        cycle();
        req = 4'd0;
        cycle();
        check("t5_hold_keeps", grant_a, 4'b0001);
        check("t5_nohold_drops", grant_b, 4'd0);
        guard = 0;
        while (grant_a != 4'd0 && guard < 40) begin
            cycle();
            guard++;
        end
        check("t5_hold_release", grant_a, 4'd0);

        // Test 6: reset mid-hold, arbitration restarts from source 0
        do_reset();
        req = 4'b0100;
        cycle();
        cycle();
        check("t6_held", grant_a, 4'b0100);
        do_reset();
        check("t6_rst_grant", grant_a, 4'd0);
        req = 4'b1111;
        cycle();
        check("t6_restart_a", grant_a, 4'b0001);
        check("t6_restart_b", grant_b, 4'b0001);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(3) == 0) pattern = 24'($urandom);
            if ($urandom_range(15) == 0) blink = 4'($urandom);
            if ($urandom_range(199) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
